// File: rtl/div_16x8_seq.sv
// ---------------------------------------------------------------------------
// div_16x8_seq
//
// Sequential unsigned restoring divider (16-bit dividend, 8-bit divisor).
// Produces the exact quotient and remainder, one quotient bit per clock,
// behind valid/ready handshakes on both the input and the output side.
// Used to recover operands from multiplier products and to score the
// multiplier's approximation error on-chip.
//
// Optional feature macro: DIV_EARLY_EXIT_EN
//   When defined, an operation whose dividend is smaller than a nonzero
//   divisor skips CALC and completes in one edge (quotient 0, remainder =
//   dividend). Results are bit-identical with or without it; only the
//   latency differs.
//
// Ports
//   clk          in   1   single clock, all logic on the rising edge
//   rst_n        in   1   synchronous active-low reset
//   in_valid     in   1   dividend/divisor presented
//   in_ready     out  1   high only in IDLE
//   dividend     in   16  unsigned dividend
//   divisor      in   8   unsigned divisor
//   out_valid    out  1   result available (DONE)
//   out_ready    in   1   consumer accepts result
//   quotient     out  16  unsigned quotient, registered
//   remainder    out  8   unsigned remainder, registered
//   div_by_zero  out  1   divisor was zero for this result
//
// FSM states
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for operands; in_ready=1, counter and partial rem clear
//   CALC  | one restoring iteration per edge, 16 edges in total
//   DONE  | result presented on out_valid until out_ready
// ---------------------------------------------------------------------------
module div_16x8_seq #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DIVISOR_W-1:0]  divisor_q;
    // Dividend shifts out of the MSB while quotient bits shift into the LSB,
    // so after the last iteration this register holds the quotient.
    logic [DIVIDEND_W-1:0] dvd_q;
    // The partial remainder is always below the divisor after an iteration,
    // so only the shifted compare value needs the extra ninth bit.
    logic [DIVISOR_W-1:0]  pr_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [DIVISOR_W:0]    pr_shift;
    logic                  q_bit;
    logic [DIVISOR_W-1:0]  pr_step;
    logic [DIVIDEND_W-1:0] dvd_step;
    logic                  last_iter;
    logic                  divisor_zero;
    logic                  early_exit;

    // ---------------------------------------------------------------------
    // One restoring iteration
    // ---------------------------------------------------------------------
    always_comb begin
        pr_shift  = {pr_q, dvd_q[DIVIDEND_W-1]};
        q_bit     = (pr_shift >= {1'b0, divisor_q});
        // When no subtraction happens pr_shift < divisor, so its top bit is 0
        // and dropping it is lossless.
        pr_step   = q_bit ? DIVISOR_W'(pr_shift - {1'b0, divisor_q})
                          : pr_shift[DIVISOR_W-1:0];
        dvd_step  = {dvd_q[DIVIDEND_W-2:0], q_bit};
        last_iter = (cnt_q == LAST_CNT);
    end

    assign divisor_zero = (divisor == '0);

`ifdef DIV_EARLY_EXIT_EN
    assign early_exit = !divisor_zero &&
                        (dividend < {{(DIVIDEND_W-DIVISOR_W){1'b0}}, divisor});
`else
    assign early_exit = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (divisor_zero || early_exit) begin
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    // ---------------------------------------------------------------------
    // Datapath and result registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            divisor_q   <= '0;
            dvd_q       <= '0;
            pr_q        <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    pr_q  <= '0;
                    cnt_q <= '0;
                    if (in_valid) begin
                        divisor_q <= divisor;
                        dvd_q     <= dividend;
                        if (divisor_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend[DIVISOR_W-1:0];
                            div_by_zero <= 1'b1;
                        end else if (early_exit) begin
                            quotient    <= '0;
                            remainder   <= dividend[DIVISOR_W-1:0];
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    pr_q  <= pr_step;
                    dvd_q <= dvd_step;
                    // Counter stops at the last iteration; IDLE clears it.
                    if (!last_iter) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        quotient    <= dvd_step;
                        remainder   <= pr_step;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_16x8_seq.sv
module tb_div_16x8_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

`ifdef DIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    div_16x8_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [15:0] a, input logic [7:0] b);
        if (b == 8'd0) return 1;
        if (EARLY && (a < {8'd0, b})) return 1;
        return 16;
    endfunction

    task automatic issue(input logic [15:0] a, input logic [7:0] b);
        chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        chk("out_valid_within_budget", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_release", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [15:0] q0;
        logic [7:0]  r0;
        logic        d0;
        logic [15:0] ra;
        logic [7:0]  rb;
        logic [15:0] eq;
        logic [7:0]  er;
        bit          seen;

        vecs[0]  = '{16'd1000,   8'd7,   16'd142,   8'd6,    1'b0};
        vecs[1]  = '{16'd65535,  8'd255, 16'd257,   8'd0,    1'b0};
        vecs[2]  = '{16'd65535,  8'd1,   16'd65535, 8'd0,    1'b0};
        vecs[3]  = '{16'h1234,   8'd0,   16'hFFFF,  8'h34,   1'b1};
        vecs[4]  = '{16'd5,      8'd9,   16'd0,     8'd5,    1'b0};
        vecs[5]  = '{16'd0,      8'd5,   16'd0,     8'd0,    1'b0};
        vecs[6]  = '{16'd255,    8'd255, 16'd1,     8'd0,    1'b0};
        vecs[7]  = '{16'd256,    8'd255, 16'd1,     8'd1,    1'b0};
        vecs[8]  = '{16'd65535,  8'd2,   16'd32767, 8'd1,    1'b0};
        vecs[9]  = '{16'd254,    8'd255, 16'd0,     8'd254,  1'b0};
        vecs[10] = '{16'd0,      8'd0,   16'hFFFF,  8'd0,    1'b1};
        vecs[11] = '{16'd40000,  8'd3,   16'd13333, 8'd1,    1'b0};
        vecs[12] = '{16'd1234,   8'd16,  16'd77,    8'd2,    1'b0};
        vecs[13] = '{16'hABCD,   8'd0,   16'hFFFF,  8'hCD,   1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 16'd0;
        divisor   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("reset_quotient",  {16'd0, quotient},     32'd0);
        chk("reset_remainder", {24'd0, remainder},    32'd0);
        chk("reset_dbz",       {31'd0, div_by_zero},  32'd0);
        chk("reset_out_valid", {31'd0, out_valid},    32'd0);
        chk("reset_in_ready",  {31'd0, in_ready},     32'd1);

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].a, vecs[i].b);
            wait_done(lat);
            chk($sformatf("vec%0d_quotient", i),  {16'd0, quotient},    {16'd0, vecs[i].q});
            chk($sformatf("vec%0d_remainder", i), {24'd0, remainder},   {24'd0, vecs[i].r});
            chk($sformatf("vec%0d_dbz", i),       {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
            chk($sformatf("vec%0d_latency", i),   32'(lat),             32'(exp_lat(vecs[i].a, vecs[i].b)));
            release_result();
        end

        // Hold the result in DONE with new operands presented.
        issue(16'd1000, 8'd7);
        wait_done(lat);
        q0 = quotient;
        r0 = remainder;
        d0 = div_by_zero;
        chk("hold_initial_quotient", {16'd0, q0}, 32'd142);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 16'h00FF;
            divisor  = 8'h02;
            @(posedge clk);
            #1;
            chk("hold_quotient",  {16'd0, quotient},    {16'd0, q0});
            chk("hold_remainder", {24'd0, remainder},   {24'd0, r0});
            chk("hold_dbz",       {31'd0, div_by_zero}, {31'd0, d0});
            chk("hold_in_ready",  {31'd0, in_ready},    32'd0);
            chk("hold_out_valid", {31'd0, out_valid},   32'd1);
        end
        // in_valid and out_ready together in DONE: only out_ready acts.
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("release_in_ready",  {31'd0, in_ready},  32'd1);
        @(posedge clk);
        #1;
        chk("no_queued_accept",  {31'd0, in_ready},  32'd1);
        chk("keep_quotient",     {16'd0, quotient},  32'd142);
        chk("keep_remainder",    {24'd0, remainder}, 32'd6);

        // Reset on the 8th CALC edge discards the operation.
        issue(16'd40000, 8'd3);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midreset_quotient",  {16'd0, quotient},    32'd0);
        chk("midreset_remainder", {24'd0, remainder},   32'd0);
        chk("midreset_dbz",       {31'd0, div_by_zero}, 32'd0);
        chk("midreset_out_valid", {31'd0, out_valid},   32'd0);
        chk("midreset_in_ready",  {31'd0, in_ready},    32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("midreset_no_result", {31'd0, seen}, 32'd0);
        issue(16'd100, 8'd10);
        wait_done(lat);
        chk("post_reset_quotient",  {16'd0, quotient},  32'd10);
        chk("post_reset_remainder", {24'd0, remainder}, 32'd0);
        chk("post_reset_latency",   32'(lat),           32'd16);
        release_result();

        // Random scoreboard against a/b and a%b.
        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom_range(0, 65535));
            if (i % 4 == 0) rb = 8'($urandom_range(0, 3));
            else            rb = 8'($urandom_range(0, 255));
            if (i % 8 == 1) ra = 16'($urandom_range(0, 300));
            if (rb == 8'd0) begin
                eq = 16'hFFFF;
                er = ra[7:0];
            end else begin
                eq = ra / {8'd0, rb};
                er = 8'(ra % {8'd0, rb});
            end
            issue(ra, rb);
            wait_done(lat);
            chk("rand_quotient",  {16'd0, quotient},    {16'd0, eq});
            chk("rand_remainder", {24'd0, remainder},   {24'd0, er});
            chk("rand_dbz",       {31'd0, div_by_zero}, {31'd0, (rb == 8'd0)});
            chk("rand_latency",   32'(lat),             32'(exp_lat(ra, rb)));
            release_result();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
